// File: rtl/step_monitor.sv
// ============================================================================
// step_monitor: per-axis step position, homing and protocol-fault tracking
// for a six-axis PU/DR/MF/Stop stepper bus.  Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module step_monitor #(
    parameter int POS_W     = 16,
    parameter int MIN_WIDTH = 25
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic [5:0]       PU,
    input  logic [5:0]       DR,
    input  logic [5:0]       MF,
    input  logic [5:0]       Stop,
    input  logic [5:0]       fault_clr,
    input  logic [2:0]       rd_axis,
    output logic [POS_W-1:0] rd_pos,
    output logic [5:0]       step_stb,
    output logic [5:0]       homed,
    output logic [5:0]       fault
);

    localparam logic [7:0]       MIN_W8  = 8'(MIN_WIDTH);
    localparam logic [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
    localparam logic [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_HIGH = 1'b0,
        ST_LOW  = 1'b1
    } state_t;

    logic [5:0] pu_s1, pu_s2, pu_d;
    logic [5:0] dr_s1, dr_s2;
    logic [5:0] mf_s1, mf_s2;
    logic [5:0] st_s1, st_s2, st_d;
    logic [5:0] pu_fall, pu_rise, st_rise;
    logic [6*POS_W-1:0] pos_flat;

    // PU idles high, so its synchroniser resets high to avoid a false edge
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            pu_s1 <= '1;
            pu_s2 <= '1;
            pu_d  <= '1;
            dr_s1 <= '0;
            dr_s2 <= '0;
            mf_s1 <= '0;
            mf_s2 <= '0;
            st_s1 <= '0;
            st_s2 <= '0;
            st_d  <= '0;
        end else begin
            pu_s1 <= PU;
            pu_s2 <= pu_s1;
            pu_d  <= pu_s2;
            dr_s1 <= DR;
            dr_s2 <= dr_s1;
            mf_s1 <= MF;
            mf_s2 <= mf_s1;
            st_s1 <= Stop;
            st_s2 <= st_s1;
            st_d  <= st_s2;
        end
    end

    assign pu_fall = pu_d & ~pu_s2;
    assign pu_rise = ~pu_d & pu_s2;
    assign st_rise = st_s2 & ~st_d;

    for (genvar i = 0; i < 6; i++) begin : g_axis
        state_t           state;
        logic [7:0]       width;
        logic             dir_lat;
        logic             step_req;
        logic             req_dir;
        logic             home_req;
        logic [POS_W-1:0] pos;
        logic             stb;
        logic             hm;
        logic             flt;
        logic             fault_now;
        logic             count_now;

        always_comb begin
            fault_now = 1'b0;
            count_now = 1'b0;
            case (state)
                ST_HIGH: begin
                    if (pu_fall[i] && !mf_s2[i])
                        fault_now = 1'b1;
                end
                ST_LOW: begin
                    if (dr_s2[i] != dir_lat)
                        fault_now = 1'b1;
                    if (pu_rise[i]) begin
                        if (width >= MIN_W8 && mf_s2[i])
                            count_now = 1'b1;
                        else
                            fault_now = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // Step/home requests pass through one register stage before the position update
        always_ff @(posedge sysclk) begin
            if (!rst_n) begin
                state    <= ST_HIGH;
                width    <= '0;
                dir_lat  <= 1'b0;
                step_req <= 1'b0;
                req_dir  <= 1'b0;
                home_req <= 1'b0;
                pos      <= '0;
                stb      <= 1'b0;
                hm       <= 1'b0;
                flt      <= 1'b0;
            end else begin
                case (state)
                    ST_HIGH: begin
                        if (pu_fall[i] && mf_s2[i]) begin
                            state   <= ST_LOW;
                            width   <= '0;
                            dir_lat <= dr_s2[i];
                        end
                    end
                    ST_LOW: begin
                        if (pu_rise[i])
                            state <= ST_HIGH;
                        else if (!pu_s2[i] && width < MIN_W8)
                            width <= width + 8'd1;
                    end
                    default: state <= ST_HIGH;
                endcase

                step_req <= count_now;
                req_dir  <= dir_lat;
                home_req <= st_rise[i];
                stb      <= step_req;
                flt      <= fault_now | (flt & ~fault_clr[i]);

                if (home_req) begin
                    pos <= '0;
                    hm  <= 1'b1;
                end else if (step_req) begin
                    if (req_dir && pos != POS_MAX)
                        pos <= pos + POS_ONE;
                    else if (!req_dir && pos != POS_MIN)
                        pos <= pos - POS_ONE;
                end
            end
        end

        assign pos_flat[i*POS_W +: POS_W] = pos;
        assign step_stb[i] = stb;
        assign homed[i]    = hm;
        assign fault[i]    = flt;
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n)
            rd_pos <= '0;
        else if (rd_axis < 3'd6)
            rd_pos <= pos_flat[rd_axis*POS_W +: POS_W];
        else
            rd_pos <= '0;
    end

endmodule

`default_nettype wire
